// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the 17-bit ISA.
// Owns the PC and drives register_file addresses/write port and ALU controls. Rev 1.0
`default_nettype none

module ctrl_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [16:0]  instr,
  input  logic         instr_valid,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  output logic         instr_ready,
  output logic [W-1:0] PC,
  output logic [2:0]   A1,
  output logic [2:0]   A2,
  output logic [2:0]   A3,
  output logic         WE,
  output logic [W-1:0] data,
  output logic [1:0]   alu_op,
  output logic         alu_src,
  output logic [W-1:0] imm,
  output logic         illegal,
  output logic         halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LI   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_pc;
  logic [W-1:0]  w_pc_nxt;
  logic [16:0]   r_ir;
  logic [16:0]   w_ir_nxt;

  logic [3:0]    w_opcode;
  logic [2:0]    w_rd;
  logic [2:0]    w_rs1;
  logic [2:0]    w_rs2;
  logic [W-1:0]  w_imm_sext;
  logic [W-1:0]  w_pc_inc;
  logic [W-1:0]  w_pc_br;
  logic          w_op_illegal;

  assign w_opcode     = r_ir[16:13];
  assign w_rd         = r_ir[12:10];
  assign w_rs1        = r_ir[9:7];
  assign w_rs2        = r_ir[6:4];
  assign w_imm_sext   = {{(W-7){r_ir[6]}}, r_ir[6:0]};
  assign w_pc_inc     = r_pc + {{(W-1){1'b0}}, 1'b1};
  assign w_pc_br      = r_pc + w_imm_sext;
  assign w_op_illegal = w_opcode[3] && (w_opcode != OP_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      S_FETCH: begin
        if (instr_valid) begin
          w_ir_nxt    = instr;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_opcode == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else if (w_op_illegal) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_opcode == OP_BEQ) begin
          w_pc_nxt    = alu_zero ? w_pc_br : w_pc_inc;
          w_state_nxt = S_FETCH;
        end else if (w_opcode == OP_JMP) begin
          w_pc_nxt    = w_pc_br;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Outputs decode from state/IR only; reset gates instr_ready so nothing is accepted while held.
  always_comb begin
    instr_ready = 1'b0;
    A1          = 3'd0;
    A2          = 3'd0;
    A3          = 3'd0;
    WE          = 1'b0;
    data        = '0;
    alu_op      = 2'b00;
    alu_src     = 1'b0;
    imm         = '0;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: instr_ready = reset;
      S_DECODE: begin
        A1      = w_rs1;
        A2      = w_rs2;
        imm     = w_imm_sext;
        illegal = w_op_illegal;
      end
      S_EXEC, S_WB: begin
        A1  = w_rs1;
        A2  = w_rs2;
        imm = w_imm_sext;
        if (w_opcode == OP_BEQ) begin
          alu_op = 2'b01;
        end else if (w_opcode[3:2] == 2'b00) begin
          alu_op = w_opcode[1:0];
        end
        alu_src = (w_opcode == OP_ADDI) || (w_opcode == OP_LI);
        if (r_state == S_WB) begin
          WE   = 1'b1;
          A3   = w_rd;
          data = (w_opcode == OP_LI) ? w_imm_sext : alu_result;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign PC = r_pc;

endmodule

`default_nettype wire

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control sequencer for the 17-bit custom-ISA processor. It sits directly upstream of register_file.
- Accepts one 17-bit instruction per fetch handshake, holds it in an instruction register (IR), and decodes it.
- Drives register_file's A1/A2/A3/WE/data/PC inputs and the ALU control signals.
- Owns the program counter.

Parameters:
W, 8, datapath/register width; must be >= 8.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
instr  input  17  instruction word from instruction memory
instr_valid  input  1  instr is valid this cycle
alu_result  input  W  ALU output, valid in EXEC/WB
alu_zero  input  1  ALU result == 0, valid in EXEC
instr_ready  output  1  sequencer accepts instr this cycle
PC  output  W  program counter (fetch address; also to register_file)
A1  output  3  read address 1 (rs1)
A2  output  3  read address 2 (rs2)
A3  output  3  write address (rd)
WE  output  1  register file write enable
data  output  W  register file write data
alu_op  output  2  00 add, 01 sub, 10 and, 11 or
alu_src  output  1  0 = RD2, 1 = imm
imm  output  W  sign-extended imm7
illegal  output  1  one-cycle pulse on an undefined opcode
halted  output  1  high in HALT

Behaviour:
- Instruction fields:
  - opcode = [16:13], rd = [12:10], rs1 = [9:7], rs2 = [6:4], imm7 = [6:0].
  - imm = imm7 sign-extended to W.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: R-type, rd = rs1 op rs2.
  - 4 ADDI: rd = rs1 + imm.
  - 5 LI: rd = imm.
  - 6 BEQ: compare rs1, rs2 (alu_op = sub); if alu_zero, PC = PC + imm, else PC + 1.
  - 7 JMP: PC = PC + imm.
  - 15 HALT.
  - 8-14: illegal; treated as NOP with illegal pulsed, PC + 1.
- Reset (asynchronous, active-low) forces, regardless of state:
  - state = FETCH, PC = 0, IR = 0.
  - WE = 0, illegal = 0, halted = 0, instr_ready = 0 in the reset cycle.
  - All address, alu_op, alu_src, imm and data outputs = 0.
  - Reset asserted mid-instruction aborts it with no write.
- FETCH:
  - instr_ready = 1.
  - On a rising edge with instr_valid = 1: IR <= instr, go to DECODE.
  - Otherwise stay in FETCH.
  - instr_ready is 0 in every other state.
- DECODE:
  - A1 = rs1, A2 = rs2, imm valid.
  - Go to EXEC.
  - Opcode 8-14: pulse illegal, PC <= PC + 1, go to FETCH.
  - Opcode 15: go to HALT.
- EXEC:
  - alu_op/alu_src driven per opcode; A1/A2 held.
  - Opcodes 0-5: go to WB.
  - BEQ/JMP: update PC as above, go to FETCH.
- WB:
  - WE = 1 for exactly this cycle, A3 = rd.
  - data = imm for LI, else alu_result.
  - PC <= PC + 1, go to FETCH.
- HALT:
  - halted = 1, WE = 0, instr_ready = 0.
  - Only reset exits.
- Outputs are registered or decoded from state/IR only; no combinational path from instr to WE/A3.
- PC arithmetic is modulo 2^W (wrap-around, no flag).
- Branch offset is two's complement: imm7 = 7'h7F gives -1.
- WE is never high outside WB; at most one write per instruction.
- Latency, counted from the accepting FETCH edge:
  - ALU/LI: 3 further cycles, the write commits at the end of WB (4 cycles/instr incl. FETCH).
  - BEQ/JMP: 3 cycles/instr.
  - Illegal: 2 cycles/instr.
- instr_valid low in FETCH: PC and all state hold indefinitely.
- rd == rs1 is legal: the read happens in DECODE/EXEC, the write in WB.

Test Plan:
1. Reset, then LI r3, 5 (opcode 5, rd 3, imm 7'h05) with instr_valid = 1 → WB cycle has WE = 1, A3 = 3, data = 8'h05; PC goes 0 → 1; WE = 0 in all other cycles.
2. ADD r1 = r2 + r4 (alu_result tied 8'h0A) → DECODE A1 = 2, A2 = 4; EXEC alu_op = 00, alu_src = 0; WB WE = 1, A3 = 1, data = 8'h0A.
3. PC = 3, BEQ imm = 7'h7E (-2): alu_zero = 1 gives PC = 1; repeat with alu_zero = 0 gives PC = 4; WE stays 0 throughout.
4. Opcode 9 → illegal high for exactly 1 cycle, no write, PC + 1. Then HALT (opcode 15) → halted = 1, instr_ready = 0 for 20+ cycles despite instr_valid = 1.
5. Assert reset (low) during EXEC of an ADD → outputs zero immediately, asynchronous, no WE pulse; on release, PC = 0, state FETCH, instr_ready = 1.
6. PC = 8'hFF, LI executed → PC wraps to 8'h00. Also hold instr_valid = 0 for 5 cycles in FETCH → PC and outputs unchanged.
